// File: rtl/mcaster_cfg_ctrl.sv
// MultiCaster row configuration sequencer.
// Walks the columns in ascending order. For each column it loads the tag,
// flushes the weight buffer, streams kernel_size weights from the host and
// waits for the buffer to go idle. When every column is done it raises
// cfg_done. Wait states are bounded by TIMEOUT. An illegal kernel size or
// an expired wait parks the sequencer in ERR until the next start.
module mcaster_cfg_ctrl #(
  parameter int DATA_WIDTH   = 16,
  parameter int NUM_COL      = 4,
  parameter int BUFFER_DEPTH = 16,
  parameter int TIMEOUT      = 255,
  parameter int TW           = $clog2(NUM_COL) + 1
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  start,
  input  logic [7:0]            kernel_size_in,
  input  logic [NUM_COL*TW-1:0] tags_in,
  input  logic                  w_valid,
  input  logic [DATA_WIDTH-1:0] w_data,
  output logic                  w_ready,
  output logic [NUM_COL-1:0]    flush_tag,
  output logic [TW-1:0]         tag_out,
  input  logic [NUM_COL-1:0]    tag_lock,
  output logic [NUM_COL-1:0]    flush_kernel,
  output logic [7:0]            kernel_size_out,
  output logic [DATA_WIDTH-1:0] fltr_data,
  output logic [NUM_COL-1:0]    fltr_we,
  input  logic [NUM_COL-1:0]    kernel_busy,
  output logic                  busy,
  output logic                  cfg_done,
  output logic                  err,
  output logic [TW-1:0]         err_col
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_TAG_FLUSH,
    S_TAG_WAIT,
    S_KER_FLUSH,
    S_KER_LOAD,
    S_KER_WAIT,
    S_NEXT,
    S_DONE,
    S_ERR
  } state_t;

  localparam logic [7:0]         LP_MAX_KS   = 8'(BUFFER_DEPTH);
  localparam logic [7:0]         LP_TO_LAST  = 8'(TIMEOUT - 1);
  localparam logic [TW-1:0]      LP_LAST_COL = TW'(NUM_COL - 1);
  localparam logic [NUM_COL-1:0] LP_ONE      = {{(NUM_COL-1){1'b0}}, 1'b1};

  state_t                  r_state;
  state_t                  w_next;
  logic [TW-1:0]           r_col;
  logic [NUM_COL*TW-1:0]   r_tags;
  logic [7:0]              r_ksize;
  logic [7:0]              r_wcnt;
  logic [7:0]              r_words;
  logic [TW-1:0]           r_err_col;
  logic [NUM_COL-1:0]      w_onehot;
  logic [TW-1:0]           w_tag;
  logic                    w_lock_hit;
  logic                    w_busy_hit;

  assign w_onehot        = LP_ONE << r_col;
  assign w_lock_hit      = |(tag_lock & w_onehot);
  assign w_busy_hit      = |(kernel_busy & w_onehot);
  assign kernel_size_out = r_ksize;
  assign err_col         = r_err_col;

  // Select the latched tag of the current column.
  always_comb begin
    w_tag = '0;
    for (int unsigned c = 0; c < NUM_COL; c++) begin
      if (r_col == TW'(c)) w_tag = r_tags[c*TW +: TW];
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state decode and per-state output strobes.
  always_comb begin
    w_next       = r_state;
    w_ready      = 1'b0;
    flush_tag    = '0;
    tag_out      = '0;
    flush_kernel = '0;
    fltr_data    = '0;
    fltr_we      = '0;
    busy         = 1'b1;
    cfg_done     = 1'b0;
    err          = 1'b0;
    case (r_state)
      S_IDLE, S_DONE, S_ERR: begin
        busy     = 1'b0;
        cfg_done = (r_state == S_DONE);
        err      = (r_state == S_ERR);
        if (start) w_next = (kernel_size_in > LP_MAX_KS) ? S_ERR : S_TAG_FLUSH;
      end
      S_TAG_FLUSH: begin
        flush_tag = w_onehot;
        tag_out   = w_tag;
        w_next    = S_TAG_WAIT;
      end
      S_TAG_WAIT: begin
        // The first cycle's tag_lock may still be the previous pass's level.
        if (w_lock_hit && (r_wcnt != 8'd0)) w_next = S_KER_FLUSH;
        else if (r_wcnt == LP_TO_LAST)      w_next = S_ERR;
      end
      S_KER_FLUSH: begin
        flush_kernel = w_onehot;
        w_next       = (r_ksize == 8'd0) ? S_KER_WAIT : S_KER_LOAD;
      end
      S_KER_LOAD: begin
        w_ready = 1'b1;
        if (w_valid) begin
          fltr_we   = w_onehot;
          fltr_data = w_data;
          if ((r_words + 8'd1) == r_ksize) w_next = S_KER_WAIT;
        end
      end
      S_KER_WAIT: begin
        if (!w_busy_hit && (r_wcnt != 8'd0)) w_next = S_NEXT;
        else if (r_wcnt == LP_TO_LAST)       w_next = S_ERR;
      end
      S_NEXT: begin
        w_next = (r_col == LP_LAST_COL) ? S_DONE : S_TAG_FLUSH;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Pass context, column index, wait and word counters.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_col     <= '0;
      r_tags    <= '0;
      r_ksize   <= '0;
      r_wcnt    <= '0;
      r_words   <= '0;
      r_err_col <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) begin
            r_col     <= '0;
            r_ksize   <= kernel_size_in;
            r_tags    <= tags_in;
            r_err_col <= '0;
          end
        end
        S_TAG_FLUSH: r_wcnt <= '0;
        S_TAG_WAIT, S_KER_WAIT: begin
          if (r_wcnt != 8'hFF) r_wcnt <= r_wcnt + 8'd1;
          if (w_next == S_ERR) r_err_col <= r_col;
        end
        S_KER_FLUSH: begin
          r_words <= '0;
          r_wcnt  <= '0;
        end
        S_KER_LOAD: begin
          if (w_valid) r_words <= r_words + 8'd1;
        end
        S_NEXT: begin
          if (r_col != LP_LAST_COL) r_col <= r_col + TW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mcaster_cfg_ctrl.sv
// Directed bench for mcaster_cfg_ctrl: a responder models tag_lock and
// kernel_busy, a host process streams weights, and a monitor logs strobes.
module tb_mcaster_cfg_ctrl;
  localparam int DW = 16;
  localparam int NC = 4;
  localparam int BD = 16;
  localparam int TO = 255;
  localparam int TW = 3;

  logic             clk = 1'b0;
  logic             rstn;
  logic             start;
  logic [7:0]       kernel_size_in;
  logic [NC*TW-1:0] tags_in;
  logic             w_valid;
  logic [DW-1:0]    w_data;
  logic             w_ready;
  logic [NC-1:0]    flush_tag;
  logic [TW-1:0]    tag_out;
  logic [NC-1:0]    tag_lock;
  logic [NC-1:0]    flush_kernel;
  logic [7:0]       kernel_size_out;
  logic [DW-1:0]    fltr_data;
  logic [NC-1:0]    fltr_we;
  logic [NC-1:0]    kernel_busy;
  logic             busy;
  logic             cfg_done;
  logic             err;
  logic [TW-1:0]    err_col;

  always #5 clk = ~clk;

  mcaster_cfg_ctrl #(
    .DATA_WIDTH(DW), .NUM_COL(NC), .BUFFER_DEPTH(BD), .TIMEOUT(TO), .TW(TW)
  ) dut (
    .clk(clk), .rstn(rstn), .start(start), .kernel_size_in(kernel_size_in),
    .tags_in(tags_in), .w_valid(w_valid), .w_data(w_data), .w_ready(w_ready),
    .flush_tag(flush_tag), .tag_out(tag_out), .tag_lock(tag_lock),
    .flush_kernel(flush_kernel), .kernel_size_out(kernel_size_out),
    .fltr_data(fltr_data), .fltr_we(fltr_we), .kernel_busy(kernel_busy),
    .busy(busy), .cfg_done(cfg_done), .err(err), .err_col(err_col)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Monitor log
  int            cyc = 0;
  logic [NC-1:0] ft_oh[$];
  logic [TW-1:0] ft_tag[$];
  int            ft_cyc[NC];
  int            fk_cyc[NC];
  int            fk_cnt[NC];
  int            we_cnt[NC];
  int            cur_col = 0;
  int            mon_bad = 0;
  int            gap_ready = 0;
  int            err_cyc = -1;
  int            done_cyc = -1;
  logic          err_prev = 1'b0;
  logic          done_prev = 1'b0;

  // Responder / host controls
  bit blk_col2 = 1'b0;
  bit lock_instant = 1'b0;
  int cur_ks = 0;
  int lock_cd[NC];
  int busy_cd[NC];
  int words_c[NC];
  int host_sent = 0;
  int gap_after = -1;
  int gap_left = 0;
  bit gap_active = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] pack_oh();
    logic [15:0] v = '0;
    for (int i = 0; i < ft_oh.size() && i < 4; i++) v[i*4 +: 4] = ft_oh[i];
    return v;
  endfunction

  function automatic logic [11:0] pack_tag();
    logic [11:0] v = '0;
    for (int i = 0; i < ft_tag.size() && i < 4; i++) v[i*3 +: 3] = ft_tag[i];
    return v;
  endfunction

  function automatic int fk_total();
    int s = 0;
    for (int c = 0; c < NC; c++) s += fk_cnt[c];
    return s;
  endfunction

  task automatic clear_mon();
    ft_oh.delete();
    ft_tag.delete();
    for (int c = 0; c < NC; c++) begin
      ft_cyc[c] = -1; fk_cyc[c] = -1; fk_cnt[c] = 0; we_cnt[c] = 0;
    end
    err_cyc = -1; done_cyc = -1; gap_ready = 0;
  endtask

  task automatic do_start(input logic [7:0] ks, input logic [NC*TW-1:0] tg);
    @(posedge clk); #1;
    clear_mon();
    cur_ks = int'(ks);
    start = 1'b1; kernel_size_in = ks; tags_in = tg;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_end(input string tag);
    int i = 0;
    while (!(cfg_done === 1'b1 || err === 1'b1) && i < 3000) begin
      @(negedge clk); i++;
    end
    chk(tag, 32'(cfg_done === 1'b1 || err === 1'b1), 1);
    repeat (2) @(negedge clk);
  endtask

  // Monitor and tag_lock/kernel_busy responder, both sampled mid-cycle.
  initial begin
    int nact;
    tag_lock = '0;
    kernel_busy = '0;
    for (int c = 0; c < NC; c++) begin lock_cd[c] = 0; busy_cd[c] = 0; words_c[c] = 0; end
    forever begin
      @(negedge clk);
      cyc++;
      nact = 0;
      if (|flush_tag) nact++;
      if (|flush_kernel) nact++;
      if (|fltr_we) nact++;
      if (nact > 1) mon_bad++;
      if ($countones(flush_tag) > 1 || $countones(flush_kernel) > 1 || $countones(fltr_we) > 1) mon_bad++;
      if (w_ready && w_valid && fltr_we == '0) mon_bad++;
      if (fltr_we != '0 && !(w_valid && w_ready)) mon_bad++;
      if (fltr_we != '0 && fltr_data !== w_data) mon_bad++;
      if (gap_active && w_ready) gap_ready++;
      if (err && !err_prev) err_cyc = cyc;
      if (cfg_done && !done_prev) done_cyc = cyc;
      err_prev = err;
      done_prev = cfg_done;
      for (int c = 0; c < NC; c++) begin
        if (flush_tag[c]) begin
          ft_oh.push_back(flush_tag); ft_tag.push_back(tag_out); ft_cyc[c] = cyc; cur_col = c;
        end
        if (flush_kernel[c]) begin
          fk_cnt[c]++; fk_cyc[c] = cyc;
          if (c != cur_col) mon_bad++;
        end
        if (fltr_we[c]) begin
          we_cnt[c]++;
          if (c != cur_col) mon_bad++;
        end
        // responder
        if (lock_cd[c] > 0) begin
          lock_cd[c]--;
          if (lock_cd[c] == 0) tag_lock[c] = 1'b1;
        end
        if (flush_tag[c]) begin
          if (lock_instant) tag_lock[c] = 1'b1;
          else begin
            tag_lock[c] = 1'b0;
            lock_cd[c] = (blk_col2 && c == 2) ? 0 : 2;
          end
        end
        if (busy_cd[c] > 0) begin
          busy_cd[c]--;
          if (busy_cd[c] == 0) kernel_busy[c] = 1'b0;
        end
        if (flush_kernel[c]) begin
          kernel_busy[c] = 1'b1; words_c[c] = 0;
          if (cur_ks == 0) busy_cd[c] = 3;
        end
        if (fltr_we[c]) begin
          words_c[c]++;
          if (words_c[c] == cur_ks) busy_cd[c] = 3;
        end
      end
    end
  end

  // Host weight source with an optional 5-cycle valid gap.
  initial begin
    bit hs;
    w_valid = 1'b1;
    w_data  = 16'h1234;
    forever begin
      @(negedge clk);
      hs = w_valid && w_ready;
      @(posedge clk); #1;
      if (hs) begin
        host_sent++;
        w_data = w_data + 16'h0111;
      end
      if (gap_left > 0) begin
        gap_left--;
        if (gap_left == 0) begin w_valid = 1'b1; gap_active = 1'b0; end
      end else if (hs && host_sent == gap_after) begin
        w_valid = 1'b0; gap_active = 1'b1; gap_left = 5;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int i;
    rstn = 1'b0; start = 1'b0; kernel_size_in = '0; tags_in = '0;
    clear_mon();
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_cfg_done", 32'(cfg_done), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_err_col", 32'(err_col), 0);
    chk("rst_w_ready", 32'(w_ready), 0);
    chk("rst_strobes", {20'd0, flush_tag, flush_kernel, fltr_we}, 0);
    chk("rst_tag_out", 32'(tag_out), 0);
    chk("rst_ksize_out", 32'(kernel_size_out), 0);
    chk("rst_fltr_data", 32'(fltr_data), 0);
    @(posedge clk); #1 rstn = 1'b1;
    @(negedge clk);

    // Nominal pass, kernel 9
    do_start(8'd9, {3'd3, 3'd2, 3'd1, 3'd0});
    @(negedge clk);
    chk("t1_busy", 32'(busy), 1);
    chk("t1_ksize_out", 32'(kernel_size_out), 9);
    chk("t1_first_flush", 32'(flush_tag), 32'h1);
    wait_end("t1_end");
    chk("t1_cfg_done", 32'(cfg_done), 1);
    chk("t1_err", 32'(err), 0);
    chk("t1_busy_done", 32'(busy), 0);
    chk("t1_w_ready_done", 32'(w_ready), 0);
    chk("t1_ft_n", ft_oh.size(), 4);
    chk("t1_ft_seq", 32'(pack_oh()), 32'h8421);
    chk("t1_tag_seq", 32'(pack_tag()), 32'h688);
    for (int c = 0; c < NC; c++) begin
      chk($sformatf("t1_we_col%0d", c), we_cnt[c], 9);
      chk($sformatf("t1_fk_col%0d", c), fk_cnt[c], 1);
    end
    chk("t1_lock_lat", fk_cyc[0] - ft_cyc[0], 3);
    chk("t1_pass_len", done_cyc - ft_cyc[0], 68);
    chk("t1_mon", mon_bad, 0);

    // Host gap mid-kernel, different tags, started from DONE
    gap_after = host_sent + 13;
    do_start(8'd9, {3'd4, 3'd7, 3'd2, 3'd5});
    @(negedge clk);
    chk("t2_done_cleared", 32'(cfg_done), 0);
    wait_end("t2_end");
    gap_after = -1;
    chk("t2_cfg_done", 32'(cfg_done), 1);
    chk("t2_tag_seq", 32'(pack_tag()), 32'h9D5);
    for (int c = 0; c < NC; c++) chk($sformatf("t2_we_col%0d", c), we_cnt[c], 9);
    chk("t2_gap_ready", gap_ready, 5);
    chk("t2_pass_len", done_cyc - ft_cyc[0], 73);
    chk("t2_mon", mon_bad, 0);

    // Zero-length kernel
    do_start(8'd0, {3'd3, 3'd2, 3'd1, 3'd0});
    wait_end("t3_end");
    chk("t3_cfg_done", 32'(cfg_done), 1);
    chk("t3_fk_total", fk_total(), 4);
    chk("t3_we_total", we_cnt[0] + we_cnt[1] + we_cnt[2] + we_cnt[3], 0);
    chk("t3_pass_len", done_cyc - ft_cyc[0], 32);

    // Largest legal kernel
    do_start(8'd16, {3'd3, 3'd2, 3'd1, 3'd0});
    wait_end("t4_end");
    chk("t4_cfg_done", 32'(cfg_done), 1);
    chk("t4_err", 32'(err), 0);
    for (int c = 0; c < NC; c++) chk($sformatf("t4_we_col%0d", c), we_cnt[c], 16);
    chk("t4_pass_len", done_cyc - ft_cyc[0], 96);

    // Column 2 never locks -> timeout
    blk_col2 = 1'b1;
    do_start(8'd2, {3'd3, 3'd2, 3'd1, 3'd0});
    @(negedge clk);
    chk("t5_busy", 32'(busy), 1);
    wait_end("t5_end");
    chk("t5_err", 32'(err), 1);
    chk("t5_err_col", 32'(err_col), 2);
    chk("t5_cfg_done", 32'(cfg_done), 0);
    chk("t5_busy_err", 32'(busy), 0);
    chk("t5_timeout_len", err_cyc - ft_cyc[2], 256);
    chk("t5_ft_n", ft_oh.size(), 3);
    chk("t5_we_col1", we_cnt[1], 2);
    chk("t5_fk_col2", fk_cnt[2], 0);
    repeat (20) @(negedge clk);
    chk("t5_err_sticky", 32'(err), 1);
    blk_col2 = 1'b0;

    // Kernel larger than the buffer
    do_start(8'd17, {3'd3, 3'd2, 3'd1, 3'd0});
    @(negedge clk);
    chk("t6_err", 32'(err), 1);
    chk("t6_err_col", 32'(err_col), 0);
    chk("t6_busy", 32'(busy), 0);
    repeat (5) @(negedge clk);
    chk("t6_no_ft", ft_oh.size(), 0);
    chk("t6_no_fk", fk_total(), 0);

    // Restart from ERR with lock already high in the first wait cycle
    lock_instant = 1'b1;
    do_start(8'd2, {3'd4, 3'd7, 3'd2, 3'd5});
    @(negedge clk);
    chk("t7_err_clear", 32'(err), 0);
    chk("t7_busy", 32'(busy), 1);
    chk("t7_first_flush", 32'(flush_tag), 32'h1);
    chk("t7_first_tag", 32'(tag_out), 5);
    wait_end("t7_end");
    lock_instant = 1'b0;
    chk("t7_cfg_done", 32'(cfg_done), 1);
    chk("t7_ft_seq", 32'(pack_oh()), 32'h8421);
    chk("t7_lock_lat", fk_cyc[0] - ft_cyc[0], 3);
    chk("t7_pass_len", done_cyc - ft_cyc[0], 40);
    chk("t7_mon", mon_bad, 0);

    // Start while busy is ignored; async reset during column 1 load
    do_start(8'd9, {3'd3, 3'd2, 3'd1, 3'd0});
    i = 0;
    while (we_cnt[1] < 2 && i < 500) begin @(negedge clk); i++; end
    chk("t8_reached_col1", 32'(we_cnt[1] >= 2), 1);
    @(posedge clk); #1;
    start = 1'b1; kernel_size_in = 8'd3; tags_in = '0;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk("t8_busy_kept", 32'(busy), 1);
    chk("t8_ksize_kept", 32'(kernel_size_out), 9);
    chk("t8_no_restart", ft_oh.size(), 2);
    @(posedge clk); #2;
    chk("t8_pre_rst_load", 32'(w_ready), 1);
    rstn = 1'b0;
    #1;
    chk("t8_rst_busy", 32'(busy), 0);
    chk("t8_rst_w_ready", 32'(w_ready), 0);
    chk("t8_rst_fltr_we", 32'(fltr_we), 0);
    chk("t8_rst_fltr_data", 32'(fltr_data), 0);
    chk("t8_rst_ksize", 32'(kernel_size_out), 0);
    @(posedge clk); @(posedge clk); #1 rstn = 1'b1;
    repeat (10) @(negedge clk);
    chk("t8_idle_ft", ft_oh.size(), 2);
    chk("t8_idle_fk2", fk_cnt[2], 0);
    chk("t8_idle_busy", 32'(busy), 0);
    chk("t8_idle_done", 32'(cfg_done), 0);
    chk("t8_mon", mon_bad, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
